// File: rtl/ob_cntrl_mk_seq.sv
// Market-order trade sequencer: query the decision stage, emit one trade record,
// then strobe pop/update on the tables and queues that hold the two matched heads.
module ob_cntrl_mk_seq #(
    parameter int QTY_W    = 16,
    parameter int UID_W    = 32,
    parameter int WAIT_MAX = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic             o_qry,
    input  logic             i_dec_vld,
    input  logic [1:0]       i_dec_kind,
    input  logic [QTY_W-1:0] i_dec_qty_a,
    input  logic [QTY_W-1:0] i_dec_qty_b,
    input  logic [UID_W-1:0] i_dec_uid_a,
    input  logic [UID_W-1:0] i_dec_uid_b,
    output logic             o_trd_vld,
    input  logic             i_trd_rdy,
    output logic [1:0]       o_trd_kind,
    output logic [UID_W-1:0] o_trd_uid_a,
    output logic [UID_W-1:0] o_trd_uid_b,
    output logic [QTY_W-1:0] o_trd_qty,
    output logic             o_bid_pop,
    output logic             o_ask_pop,
    output logic             o_mkb_pop,
    output logic             o_mks_pop,
    output logic             o_bid_upd,
    output logic             o_ask_upd,
    output logic             o_mkb_upd,
    output logic             o_mks_upd,
    output logic [QTY_W-1:0] o_upd_qty,
    output logic             o_busy,
    output logic             o_abandon,
    output logic [31:0]      o_trd_cnt
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_QRY  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_UPD  = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_waitCnt;
    logic [1:0]       r_kind;
    logic [QTY_W-1:0] r_qtyA;
    logic [QTY_W-1:0] r_qtyB;
    logic [UID_W-1:0] r_uidA;
    logic [UID_W-1:0] r_uidB;
    logic             r_abandon;
    logic [31:0]      r_trdCnt;

    // A kind of 0 is not a real trade, so it ends the sequence like a timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_waitCnt <= '0;
            r_kind    <= '0;
            r_qtyA    <= '0;
            r_qtyB    <= '0;
            r_uidA    <= '0;
            r_uidB    <= '0;
            r_abandon <= 1'b0;
            r_trdCnt  <= '0;
        end else begin
            r_abandon <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_en) r_state <= S_QRY;
                end
                S_QRY: begin
                    r_waitCnt <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_dec_vld) begin
                        if (i_dec_kind == 2'd0) begin
                            r_abandon <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_kind  <= i_dec_kind;
                            r_qtyA  <= i_dec_qty_a;
                            r_qtyB  <= i_dec_qty_b;
                            r_uidA  <= i_dec_uid_a;
                            r_uidB  <= i_dec_uid_b;
                            r_state <= S_EMIT;
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt + CNT_W'(1);
                        if (r_waitCnt == CNT_W'(WAIT_MAX - 1)) begin
                            r_abandon <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                S_EMIT: begin
                    if (i_trd_rdy) begin
                        r_trdCnt <= r_trdCnt + 32'd1;
                        r_state  <= S_UPD;
                    end
                end
                S_UPD: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    logic [QTY_W:0] w_diffAB;
    logic [QTY_W:0] w_diffBA;
    logic           w_aGtB;
    logic           w_bGtA;
    logic           w_inUpd;
    logic           w_popA;
    logic           w_popB;
    logic           w_updA;
    logic           w_updB;
    logic           w_k1;
    logic           w_k2;
    logic           w_k3;

    // The borrow out of each widened subtraction doubles as the unsigned compare.
    assign w_diffAB = {1'b0, r_qtyA} - {1'b0, r_qtyB};
    assign w_diffBA = {1'b0, r_qtyB} - {1'b0, r_qtyA};
    assign w_bGtA   = w_diffAB[QTY_W];
    assign w_aGtB   = w_diffBA[QTY_W];

    assign w_inUpd = (r_state == S_UPD);
    assign w_popA  = w_inUpd & ~w_aGtB;
    assign w_popB  = w_inUpd & ~w_bGtA;
    assign w_updA  = w_inUpd & w_aGtB;
    assign w_updB  = w_inUpd & w_bGtA;

    assign w_k1 = (r_kind == 2'd1);
    assign w_k2 = (r_kind == 2'd2);
    assign w_k3 = (r_kind == 2'd3);

    // Side A is bid/ask/mkb and side B is mks/mkb/mks for kinds 1/2/3.
    assign o_bid_pop = w_popA & w_k1;
    assign o_ask_pop = w_popA & w_k2;
    assign o_mkb_pop = (w_popA & w_k3) | (w_popB & w_k2);
    assign o_mks_pop = w_popB & (w_k1 | w_k3);
    assign o_bid_upd = w_updA & w_k1;
    assign o_ask_upd = w_updA & w_k2;
    assign o_mkb_upd = (w_updA & w_k3) | (w_updB & w_k2);
    assign o_mks_upd = w_updB & (w_k1 | w_k3);

    assign o_upd_qty = w_updA ? w_diffAB[QTY_W-1:0] :
                       w_updB ? w_diffBA[QTY_W-1:0] : '0;

    assign o_qry       = (r_state == S_QRY);
    assign o_trd_vld   = (r_state == S_EMIT);
    assign o_trd_kind  = r_kind;
    assign o_trd_uid_a = r_uidA;
    assign o_trd_uid_b = r_uidB;
    assign o_trd_qty   = w_bGtA ? r_qtyA : r_qtyB;
    assign o_busy      = (r_state != S_IDLE);
    assign o_abandon   = r_abandon;
    assign o_trd_cnt   = r_trdCnt;

endmodule

// File: tb/tb_ob_cntrl_mk_seq.sv
// Bench for ob_cntrl_mk_seq: directed vector table, randomized transactions against a
// transaction-level model, and hand-written reset-in-EMIT sequence.
module tb_ob_cntrl_mk_seq;

    localparam int WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        rst, en, qry, decVld, trdVld, trdRdy;
    logic [1:0]  decKind, trdKind;
    logic [15:0] decQtyA, decQtyB, trdQty, updQty;
    logic [31:0] decUidA, decUidB, trdUidA, trdUidB, trdCnt;
    logic        bidPop, askPop, mkbPop, mksPop, bidUpd, askUpd, mkbUpd, mksUpd;
    logic        busy, abandon;

    int checks = 0;
    int errors = 0;
    int expCnt = 0;

    always #5 clk = ~clk;

    ob_cntrl_mk_seq #(.QTY_W(16), .UID_W(32), .WAIT_MAX(WAIT_MAX)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .o_qry(qry),
        .i_dec_vld(decVld), .i_dec_kind(decKind),
        .i_dec_qty_a(decQtyA), .i_dec_qty_b(decQtyB),
        .i_dec_uid_a(decUidA), .i_dec_uid_b(decUidB),
        .o_trd_vld(trdVld), .i_trd_rdy(trdRdy), .o_trd_kind(trdKind),
        .o_trd_uid_a(trdUidA), .o_trd_uid_b(trdUidB), .o_trd_qty(trdQty),
        .o_bid_pop(bidPop), .o_ask_pop(askPop), .o_mkb_pop(mkbPop), .o_mks_pop(mksPop),
        .o_bid_upd(bidUpd), .o_ask_upd(askUpd), .o_mkb_upd(mkbUpd), .o_mks_upd(mksUpd),
        .o_upd_qty(updQty), .o_busy(busy), .o_abandon(abandon), .o_trd_cnt(trdCnt)
    );

    // Strobe bit order in both vectors: 0=bid 1=ask 2=mkb 3=mks.
    typedef struct {
        logic [1:0]  kind;
        logic [15:0] qtyA;
        logic [15:0] qtyB;
        logic [31:0] uidA;
        logic [31:0] uidB;
        int          vldDly;
        int          stall;
        logic        expAbandon;
        logic [15:0] expFill;
        logic [3:0]  expPop;
        logic [3:0]  expUpd;
        logic [15:0] expResid;
    } vec_t;

    function automatic vec_t mkVec(input logic [1:0] kind, input logic [15:0] a, input logic [15:0] b,
                                   input logic [31:0] ua, input logic [31:0] ub, input int d, input int s,
                                   input logic ab, input logic [15:0] fill, input logic [3:0] pop,
                                   input logic [3:0] upd, input logic [15:0] resid);
        vec_t v;
        v.kind = kind; v.qtyA = a; v.qtyB = b; v.uidA = ua; v.uidB = ub;
        v.vldDly = d; v.stall = s; v.expAbandon = ab; v.expFill = fill;
        v.expPop = pop; v.expUpd = upd; v.expResid = resid;
        return v;
    endfunction

    // Transaction-level reference: which book entry each side names, and what is left over.
    function automatic vec_t model(input vec_t vin);
        vec_t v;
        int sideA[4];
        int sideB[4];
        int a, b;
        v = vin;
        sideA = '{0, 0, 1, 2};
        sideB = '{0, 3, 2, 3};
        a = int'(v.qtyA);
        b = int'(v.qtyB);
        v.expAbandon = (v.kind == 2'd0) || (v.vldDly >= WAIT_MAX);
        v.expFill    = 16'((a < b) ? a : b);
        v.expPop     = '0;
        v.expUpd     = '0;
        v.expResid   = '0;
        if (!v.expAbandon) begin
            if (a >= b) v.expPop[sideB[v.kind]] = 1'b1;
            if (b >= a) v.expPop[sideA[v.kind]] = 1'b1;
            if (a > b) begin
                v.expUpd[sideA[v.kind]] = 1'b1;
                v.expResid = 16'(a - b);
            end else if (b > a) begin
                v.expUpd[sideB[v.kind]] = 1'b1;
                v.expResid = 16'(b - a);
            end
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Runs one transaction from IDLE, sampling every negedge; cycle 1 is the QRY cycle.
    task automatic applyStimulus(input vec_t v, input string tag);
        int qryCount = 0, qryCyc = -1, emitCount = 0, strobeCycles = 0;
        int abandonCyc = -1, endCyc = -1, expAbCyc;
        logic [3:0] popSeen = '0, updSeen = '0, popVec, updVec;
        logic [15:0] residSeen = '0;
        logic [1:0]  fKind = '0;
        logic [31:0] fUidA = '0, fUidB = '0;
        logic [15:0] fQty = '0;
        logic        unstable = 1'b0;

        en = 1'b1; decVld = 1'b0;
        trdRdy = (v.stall == 0);
        for (int c = 1; c <= 60 && endCyc < 0; c++) begin
            @(negedge clk);
            en = 1'b0;
            popVec = {mksPop, mkbPop, askPop, bidPop};
            updVec = {mksUpd, mkbUpd, askUpd, bidUpd};
            if (qry) begin qryCount++; qryCyc = c; end
            if (abandon) abandonCyc = c;
            if (trdVld) begin
                emitCount++;
                if (emitCount == 1) begin
                    fKind = trdKind; fUidA = trdUidA; fUidB = trdUidB; fQty = trdQty;
                end else if (fKind !== trdKind || fUidA !== trdUidA || fUidB !== trdUidB || fQty !== trdQty) begin
                    unstable = 1'b1;
                end
                trdRdy = (v.stall == 0) || (emitCount > v.stall);
            end
            if ((popVec | updVec) != 4'd0) begin
                strobeCycles++;
                popSeen |= popVec;
                updSeen |= updVec;
                residSeen = updQty;
            end
            if (c > 1 && !busy) endCyc = c;
            if (c == 2 + v.vldDly) begin
                decVld = 1'b1; decKind = v.kind;
                decQtyA = v.qtyA; decQtyB = v.qtyB; decUidA = v.uidA; decUidB = v.uidB;
            end else if (c == 1 || c > 2 + v.vldDly) begin
                // Junk decisions outside WAIT must never be captured.
                decVld = 1'($urandom_range(0, 1)); decKind = 2'($urandom_range(1, 3));
                decQtyA = 16'($urandom); decQtyB = 16'($urandom);
                decUidA = $urandom; decUidB = $urandom;
            end else begin
                decVld = 1'b0;
            end
        end
        decVld = 1'b0;
        trdRdy = 1'b0;

        checkOutput({tag, ".done"}, 64'(endCyc >= 0), 64'd1);
        checkOutput({tag, ".qryCount"}, 64'(qryCount), 64'd1);
        checkOutput({tag, ".qryCyc"}, 64'(qryCyc), 64'd1);
        if (v.expAbandon) begin
            expAbCyc = (v.kind == 2'd0 && v.vldDly < WAIT_MAX) ? 3 + v.vldDly : 2 + WAIT_MAX;
            checkOutput({tag, ".abandonCyc"}, 64'(abandonCyc), 64'(expAbCyc));
            checkOutput({tag, ".endCyc"}, 64'(endCyc), 64'(expAbCyc));
            checkOutput({tag, ".emitCount"}, 64'(emitCount), 64'd0);
            checkOutput({tag, ".strobeCycles"}, 64'(strobeCycles), 64'd0);
        end else begin
            expCnt++;
            checkOutput({tag, ".abandonCyc"}, 64'(abandonCyc), -64'sd1);
            checkOutput({tag, ".emitCount"}, 64'(emitCount), 64'(v.stall + 1));
            checkOutput({tag, ".trdKind"}, 64'(fKind), 64'(v.kind));
            checkOutput({tag, ".trdUidA"}, 64'(fUidA), 64'(v.uidA));
            checkOutput({tag, ".trdUidB"}, 64'(fUidB), 64'(v.uidB));
            checkOutput({tag, ".trdQty"}, 64'(fQty), 64'(v.expFill));
            checkOutput({tag, ".trdStable"}, 64'(unstable), 64'd0);
            checkOutput({tag, ".strobeCycles"}, 64'(strobeCycles), 64'd1);
            checkOutput({tag, ".pop"}, 64'(popSeen), 64'(v.expPop));
            checkOutput({tag, ".upd"}, 64'(updSeen), 64'(v.expUpd));
            checkOutput({tag, ".updQty"}, 64'(residSeen), 64'(v.expResid));
            checkOutput({tag, ".endCyc"}, 64'(endCyc), 64'(5 + v.vldDly + v.stall));
        end
        checkOutput({tag, ".trdCnt"}, 64'(trdCnt), 64'(expCnt));
    endtask

    vec_t dirTab[9];
    vec_t rv;

    initial begin
        rst = 1'b1; en = 1'b0; decVld = 1'b0; trdRdy = 1'b0; decKind = '0;
        decQtyA = '0; decQtyB = '0; decUidA = '0; decUidB = '0;

        dirTab[0] = mkVec(2'd1, 16'd10, 16'd4, 32'hA001, 32'hB001, 0, 0, 1'b0, 16'd4, 4'b1000, 4'b0001, 16'd6);
        dirTab[1] = mkVec(2'd3, 16'd7,  16'd7, 32'hA002, 32'hB002, 0, 0, 1'b0, 16'd7, 4'b1100, 4'b0000, 16'd0);
        dirTab[2] = mkVec(2'd2, 16'd3,  16'd9, 32'hDEADBEEF, 32'h12345678, 1, 0, 1'b0, 16'd3, 4'b0010, 4'b0100, 16'd6);
        dirTab[3] = mkVec(2'd1, 16'd5,  16'd5, 32'hA003, 32'hB003, 4, 0, 1'b1, 16'd0, 4'b0000, 4'b0000, 16'd0);
        dirTab[4] = mkVec(2'd1, 16'd5,  16'd5, 32'hA004, 32'hB004, 0, 20, 1'b0, 16'd5, 4'b1001, 4'b0000, 16'd0);
        dirTab[5] = mkVec(2'd0, 16'd2,  16'd1, 32'hA005, 32'hB005, 1, 0, 1'b1, 16'd0, 4'b0000, 4'b0000, 16'd0);
        dirTab[6] = mkVec(2'd2, 16'd0,  16'd8, 32'hA006, 32'hB006, 2, 1, 1'b0, 16'd0, 4'b0010, 4'b0100, 16'd8);
        dirTab[7] = mkVec(2'd3, 16'hFFFF, 16'd1, 32'hA007, 32'hB007, 3, 0, 1'b0, 16'd1, 4'b1000, 4'b0100, 16'hFFFE);
        dirTab[8] = mkVec(2'd1, 16'd0,  16'd0, 32'hA008, 32'hB008, 0, 2, 1'b0, 16'd0, 4'b1001, 4'b0000, 16'd0);

        repeat (3) @(negedge clk);
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.qry", 64'(qry), 64'd0);
        checkOutput("reset.trdVld", 64'(trdVld), 64'd0);
        checkOutput("reset.strobes", 64'({bidPop, askPop, mkbPop, mksPop, bidUpd, askUpd, mkbUpd, mksUpd}), 64'd0);
        checkOutput("reset.updQty", 64'(updQty), 64'd0);
        checkOutput("reset.abandon", 64'(abandon), 64'd0);
        checkOutput("reset.trdCnt", 64'(trdCnt), 64'd0);
        checkOutput("reset.trdQty", 64'(trdQty), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) applyStimulus(dirTab[i], $sformatf("dir%0d", i));

        for (int i = 0; i < 25; i++) begin
            rv.kind = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) begin
                rv.qtyA = 16'($urandom_range(0, 6));
                rv.qtyB = 16'($urandom_range(0, 6));
            end else begin
                rv.qtyA = 16'($urandom);
                rv.qtyB = 16'($urandom);
            end
            rv.uidA = $urandom; rv.uidB = $urandom;
            rv.vldDly = $urandom_range(0, 5);
            rv.stall = $urandom_range(0, 4);
            applyStimulus(model(rv), $sformatf("rnd%0d", i));
        end

        // Reset while a trade sits in EMIT: it must vanish without strobes or a count.
        @(negedge clk); en = 1'b1; trdRdy = 1'b0;
        @(negedge clk); en = 1'b0;
        decVld = 1'b1; decKind = 2'd1; decQtyA = 16'd9; decQtyB = 16'd2;
        decUidA = 32'h1111; decUidB = 32'h2222;
        @(negedge clk);
        @(negedge clk); decVld = 1'b0;
        checkOutput("rstEmit.inEmit", 64'(trdVld), 64'd1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checkOutput("rstEmit.busy", 64'(busy), 64'd0);
        checkOutput("rstEmit.trdVld", 64'(trdVld), 64'd0);
        checkOutput("rstEmit.trdCnt", 64'(trdCnt), 64'd0);
        trdRdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("rstEmit.strobes%0d", c),
                        64'({bidPop, askPop, mkbPop, mksPop, bidUpd, askUpd, mkbUpd, mksUpd}), 64'd0);
            @(negedge clk);
        end
        expCnt = 0;
        applyStimulus(dirTab[0], "afterRst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
